// File: rtl/led_adc_scheduler_pkg.sv
// Shared definitions for the LED/ADC scheduler: FSM states, phase encoding and
// the default cycle budgets that the FIR filter clock planning also relies on.
package led_adc_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_WAIT_DONE,
        ST_HOLD
    } sched_state_e;

    localparam logic PHASE_RED = 1'b0;
    localparam logic PHASE_IR  = 1'b1;

    // 10 MHz system clock: 5 ms per LED phase, 1 ms settle, 100 us ADC budget.
    localparam int DEFAULT_HALF_PERIOD_CYC = 50000;
    localparam int DEFAULT_SETTLE_CYC      = 10000;
    localparam int DEFAULT_ADC_TIMEOUT_CYC = 1000;

endpackage

// File: rtl/led_adc_scheduler_phase_timer.sv
// Free-running counter with clear and enable that wraps to zero after LAST and
// flags the terminal count; used for both the LED phase and the ADC wait.
module led_adc_scheduler_phase_timer #(
    parameter int LAST  = 1,
    parameter int WIDTH = (LAST < 1) ? 1 : $clog2(LAST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc    = (count_q == LAST_V);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_adc_scheduler.sv
// Alternates the red/IR LEDs, triggers one ADC conversion per LED phase after
// the optical settle time, and steers each result to its channel with a strobe.
module led_adc_scheduler
    import led_adc_scheduler_pkg::*;
#(
    parameter int HALF_PERIOD_CYC = DEFAULT_HALF_PERIOD_CYC,
    parameter int SETTLE_CYC      = DEFAULT_SETTLE_CYC,
    parameter int ADC_TIMEOUT_CYC = DEFAULT_ADC_TIMEOUT_CYC
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       Enable,
    input  logic       Err_Clr,
    input  logic [7:0] ADC_Data,
    input  logic       ADC_Done,
    output logic       ADC_Start,
    output logic       LED_RED_On,
    output logic       LED_IR_On,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic       RED_Sample_Valid,
    output logic       IR_Sample_Valid,
    output logic       ADC_Timeout_Err
);

    localparam int PW = (HALF_PERIOD_CYC > 1) ? $clog2(HALF_PERIOD_CYC) : 1;
    localparam int WW = (ADC_TIMEOUT_CYC > 1) ? $clog2(ADC_TIMEOUT_CYC) : 1;
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYC - 1);

    sched_state_e state_q, state_d;
    logic         phase_q, phase_d;
    logic [7:0]   red_val_q, red_val_d;
    logic [7:0]   ir_val_q, ir_val_d;
    logic         red_valid_q, red_valid_d;
    logic         ir_valid_q, ir_valid_d;
    logic         err_q, err_d;
    logic         adc_start_q, adc_start_d;
    logic         led_red_q, led_red_d;
    logic         led_ir_q, led_ir_d;
    logic         set_err;

    logic [PW-1:0] phase_count;
    logic          phase_tc;
    logic [WW-1:0] wait_count;
    logic          wait_tc;
    logic          phase_clr, phase_en, wait_clr, wait_en;

    assign phase_clr = (state_q == ST_IDLE) || !Enable;
    assign phase_en  = (state_q != ST_IDLE);
    assign wait_clr  = (state_q != ST_WAIT_DONE);
    assign wait_en   = (state_q == ST_WAIT_DONE);

    led_adc_scheduler_phase_timer #(
        .LAST  (HALF_PERIOD_CYC - 1),
        .WIDTH (PW)
    ) u_phase_timer (
        .clk   (CLK),
        .rst   (rst),
        .clr   (phase_clr),
        .en    (phase_en),
        .count (phase_count),
        .tc    (phase_tc)
    );

    led_adc_scheduler_phase_timer #(
        .LAST  (ADC_TIMEOUT_CYC - 1),
        .WIDTH (WW)
    ) u_wait_timer (
        .clk   (CLK),
        .rst   (rst),
        .clr   (wait_clr),
        .en    (wait_en),
        .count (wait_count),
        .tc    (wait_tc)
    );

    // Enable drop beats the phase wrap, which in turn overrides whatever step is in progress.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        red_val_d   = red_val_q;
        ir_val_d    = ir_val_q;
        red_valid_d = 1'b0;
        ir_valid_d  = 1'b0;
        set_err     = 1'b0;

        if (!Enable) begin
            state_d = ST_IDLE;
            phase_d = PHASE_RED;
        end else if ((state_q != ST_IDLE) && phase_tc) begin
            state_d = ST_SETTLE;
            phase_d = ~phase_q;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_SETTLE;
                ST_SETTLE:  if (phase_count == SETTLE_LAST) state_d = ST_CONVERT;
                ST_CONVERT: state_d = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (ADC_Done) begin
                        state_d = ST_HOLD;
                        if (phase_q == PHASE_RED) begin
                            red_val_d   = ADC_Data;
                            red_valid_d = 1'b1;
                        end else begin
                            ir_val_d   = ADC_Data;
                            ir_valid_d = 1'b1;
                        end
                    end else if (wait_tc) begin
                        state_d = ST_HOLD;
                        set_err = 1'b1;
                    end
                end
                default:    state_d = state_q;
            endcase
        end

        err_d       = set_err | (err_q & ~Err_Clr);
        adc_start_d = (state_d == ST_CONVERT);
        led_red_d   = (state_d != ST_IDLE) && (phase_d == PHASE_RED);
        led_ir_d    = (state_d != ST_IDLE) && (phase_d == PHASE_IR);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PHASE_RED;
            red_val_q   <= 8'd0;
            ir_val_q    <= 8'd0;
            red_valid_q <= 1'b0;
            ir_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            adc_start_q <= 1'b0;
            led_red_q   <= 1'b0;
            led_ir_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            red_val_q   <= red_val_d;
            ir_val_q    <= ir_val_d;
            red_valid_q <= red_valid_d;
            ir_valid_q  <= ir_valid_d;
            err_q       <= err_d;
            adc_start_q <= adc_start_d;
            led_red_q   <= led_red_d;
            led_ir_q    <= led_ir_d;
        end
    end

    assign ADC_Start        = adc_start_q;
    assign LED_RED_On       = led_red_q;
    assign LED_IR_On        = led_ir_q;
    assign RED_ADC_Value    = red_val_q;
    assign IR_ADC_Value     = ir_val_q;
    assign RED_Sample_Valid = red_valid_q;
    assign IR_Sample_Valid  = ir_valid_q;
    assign ADC_Timeout_Err  = err_q;

endmodule

// File: tb/tb_led_adc_scheduler.sv
// Directed bench for led_adc_scheduler with shortened timing (100/10/20 cycles):
// a per-cycle vector table for the steady schedule plus hand sequences for Enable and rst.
module tb_led_adc_scheduler;

    localparam int HALF    = 100;
    localparam int SETTLE  = 10;
    localparam int TIMEOUT = 20;

    logic       CLK = 1'b0;
    logic       rst;
    logic       Enable;
    logic       Err_Clr;
    logic [7:0] ADC_Data;
    logic       ADC_Done;
    logic       ADC_Start;
    logic       LED_RED_On;
    logic       LED_IR_On;
    logic [7:0] RED_ADC_Value;
    logic [7:0] IR_ADC_Value;
    logic       RED_Sample_Valid;
    logic       IR_Sample_Valid;
    logic       ADC_Timeout_Err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic        done;
        logic [7:0]  data;
        logic        clr;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    led_adc_scheduler #(
        .HALF_PERIOD_CYC (HALF),
        .SETTLE_CYC      (SETTLE),
        .ADC_TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .CLK              (CLK),
        .rst              (rst),
        .Enable           (Enable),
        .Err_Clr          (Err_Clr),
        .ADC_Data         (ADC_Data),
        .ADC_Done         (ADC_Done),
        .ADC_Start        (ADC_Start),
        .LED_RED_On       (LED_RED_On),
        .LED_IR_On        (LED_IR_On),
        .RED_ADC_Value    (RED_ADC_Value),
        .IR_ADC_Value     (IR_ADC_Value),
        .RED_Sample_Valid (RED_Sample_Valid),
        .IR_Sample_Valid  (IR_Sample_Valid),
        .ADC_Timeout_Err  (ADC_Timeout_Err)
    );

    always #5 CLK = ~CLK;

    // Expected output bundle: {start, red, ir, red_valid, ir_valid, err, red_value, ir_value}
    function automatic logic [21:0] pk(input logic st, input logic red, input logic ir,
                                       input logic rv, input logic iv, input logic err,
                                       input logic [7:0] rval, input logic [7:0] ival);
        return {st, red, ir, rv, iv, err, rval, ival};
    endfunction

    function automatic vec_t mk(input int c, input logic d, input logic [7:0] dat,
                                input logic clr, input logic [21:0] e);
        vec_t v;
        v.cyc  = c;
        v.done = d;
        v.data = dat;
        v.clr  = clr;
        v.exp  = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int c, input logic [21:0] exp);
        logic [21:0] got;
        got = {ADC_Start, LED_RED_On, LED_IR_On, RED_Sample_Valid, IR_Sample_Valid,
               ADC_Timeout_Err, RED_ADC_Value, IR_ADC_Value};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got {st,red,ir,rv,iv,err,rval,ival}=%b%b%b%b%b%b_%h_%h expected %b%b%b%b%b%b_%h_%h",
                     name, c, got[21], got[20], got[19], got[18], got[17], got[16], got[15:8], got[7:0],
                     exp[21], exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ADC_Done = v.done;
        ADC_Data = v.data;
        Err_Clr  = v.clr;
    endtask

    // One clock; pulse inputs drop right after the edge, outputs are sampled on the falling edge.
    task automatic step();
        @(posedge CLK);
        #1;
        ADC_Done = 1'b0;
        Err_Clr  = 1'b0;
        @(negedge CLK);
        cyc++;
        checks++;
        if (LED_RED_On && LED_IR_On) begin
            errors++;
            $display("[TB] FAIL led_overlap cyc=%0d got red=%b ir=%b expected never both 1",
                     cyc, LED_RED_On, LED_IR_On);
        end
    endtask

    task automatic stepTo(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        rst      = 1'b1;
        Enable   = 1'b0;
        Err_Clr  = 1'b0;
        ADC_Done = 1'b0;
        ADC_Data = 8'h00;

        vecs.push_back(mk(0,   0, 8'h00, 0, pk(0,1,0,0,0,0,8'h00,8'h00)));
        vecs.push_back(mk(9,   0, 8'h00, 0, pk(0,1,0,0,0,0,8'h00,8'h00)));
        vecs.push_back(mk(10,  0, 8'h00, 0, pk(1,1,0,0,0,0,8'h00,8'h00)));
        vecs.push_back(mk(11,  0, 8'h00, 0, pk(0,1,0,0,0,0,8'h00,8'h00)));
        vecs.push_back(mk(13,  1, 8'h5A, 0, pk(0,1,0,0,0,0,8'h00,8'h00)));
        vecs.push_back(mk(14,  0, 8'h00, 0, pk(0,1,0,1,0,0,8'h5A,8'h00)));
        vecs.push_back(mk(15,  0, 8'h00, 0, pk(0,1,0,0,0,0,8'h5A,8'h00)));
        vecs.push_back(mk(99,  0, 8'h00, 0, pk(0,1,0,0,0,0,8'h5A,8'h00)));
        vecs.push_back(mk(100, 0, 8'h00, 0, pk(0,0,1,0,0,0,8'h5A,8'h00)));
        vecs.push_back(mk(109, 0, 8'h00, 0, pk(0,0,1,0,0,0,8'h5A,8'h00)));
        vecs.push_back(mk(110, 0, 8'h00, 0, pk(1,0,1,0,0,0,8'h5A,8'h00)));
        vecs.push_back(mk(113, 1, 8'hA5, 0, pk(0,0,1,0,0,0,8'h5A,8'h00)));
        vecs.push_back(mk(114, 0, 8'h00, 0, pk(0,0,1,0,1,0,8'h5A,8'hA5)));
        vecs.push_back(mk(115, 0, 8'h00, 0, pk(0,0,1,0,0,0,8'h5A,8'hA5)));
        vecs.push_back(mk(199, 0, 8'h00, 0, pk(0,0,1,0,0,0,8'h5A,8'hA5)));
        vecs.push_back(mk(200, 0, 8'h00, 0, pk(0,1,0,0,0,0,8'h5A,8'hA5)));
        vecs.push_back(mk(210, 0, 8'h00, 0, pk(1,1,0,0,0,0,8'h5A,8'hA5)));
        vecs.push_back(mk(213, 1, 8'h3C, 0, pk(0,1,0,0,0,0,8'h5A,8'hA5)));
        vecs.push_back(mk(214, 0, 8'h00, 0, pk(0,1,0,1,0,0,8'h3C,8'hA5)));
        vecs.push_back(mk(300, 0, 8'h00, 0, pk(0,0,1,0,0,0,8'h3C,8'hA5)));
        vecs.push_back(mk(310, 0, 8'h00, 0, pk(1,0,1,0,0,0,8'h3C,8'hA5)));
        vecs.push_back(mk(330, 0, 8'h00, 0, pk(0,0,1,0,0,0,8'h3C,8'hA5)));
        vecs.push_back(mk(331, 0, 8'h00, 0, pk(0,0,1,0,0,1,8'h3C,8'hA5)));
        vecs.push_back(mk(332, 0, 8'h00, 0, pk(0,0,1,0,0,1,8'h3C,8'hA5)));
        vecs.push_back(mk(400, 0, 8'h00, 0, pk(0,1,0,0,0,1,8'h3C,8'hA5)));
        vecs.push_back(mk(405, 0, 8'h00, 1, pk(0,1,0,0,0,1,8'h3C,8'hA5)));
        vecs.push_back(mk(406, 0, 8'h00, 0, pk(0,1,0,0,0,0,8'h3C,8'hA5)));
        vecs.push_back(mk(410, 0, 8'h00, 0, pk(1,1,0,0,0,0,8'h3C,8'hA5)));
        vecs.push_back(mk(430, 0, 8'h00, 1, pk(0,1,0,0,0,0,8'h3C,8'hA5)));
        vecs.push_back(mk(431, 0, 8'h00, 0, pk(0,1,0,0,0,1,8'h3C,8'hA5)));
        vecs.push_back(mk(432, 0, 8'h00, 0, pk(0,1,0,0,0,1,8'h3C,8'hA5)));
        vecs.push_back(mk(500, 0, 8'h00, 0, pk(0,0,1,0,0,1,8'h3C,8'hA5)));
        vecs.push_back(mk(505, 0, 8'h00, 1, pk(0,0,1,0,0,1,8'h3C,8'hA5)));
        vecs.push_back(mk(506, 0, 8'h00, 0, pk(0,0,1,0,0,0,8'h3C,8'hA5)));
        vecs.push_back(mk(530, 1, 8'h77, 0, pk(0,0,1,0,0,0,8'h3C,8'hA5)));
        vecs.push_back(mk(531, 0, 8'h00, 0, pk(0,0,1,0,1,0,8'h3C,8'h77)));
        vecs.push_back(mk(532, 0, 8'h00, 0, pk(0,0,1,0,0,0,8'h3C,8'h77)));

        repeat (2) @(negedge CLK);
        checkOutput("reset_state", 0, pk(0,0,0,0,0,0,8'h00,8'h00));
        rst = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("idle_disabled", 0, pk(0,0,0,0,0,0,8'h00,8'h00));

        Enable = 1'b1;
        cyc = -1;
        step();
        foreach (vecs[i]) begin
            stepTo(vecs[i].cyc);
            checkOutput("vector", vecs[i].cyc, vecs[i].exp);
            applyStimulus(vecs[i]);
        end

        // Drop Enable while the red conversion is pending, then let a stale Done arrive.
        stepTo(612);
        checkOutput("wait_done_red", cyc, pk(0,1,0,0,0,0,8'h3C,8'h77));
        Enable = 1'b0;
        step();
        checkOutput("enable_drop_idle", cyc, pk(0,0,0,0,0,0,8'h3C,8'h77));
        ADC_Done = 1'b1;
        ADC_Data = 8'hEE;
        step();
        checkOutput("done_ignored_idle", cyc, pk(0,0,0,0,0,0,8'h3C,8'h77));

        Enable = 1'b1;
        cyc = -1;
        step();
        checkOutput("restart_cnt0", cyc, pk(0,1,0,0,0,0,8'h3C,8'h77));
        stepTo(9);
        checkOutput("restart_cnt9", cyc, pk(0,1,0,0,0,0,8'h3C,8'h77));
        stepTo(10);
        checkOutput("restart_start", cyc, pk(1,1,0,0,0,0,8'h3C,8'h77));
        stepTo(13);
        ADC_Done = 1'b1;
        ADC_Data = 8'h12;
        step();
        checkOutput("restart_sample", cyc, pk(0,1,0,1,0,0,8'h12,8'h77));
        stepTo(20);

        // Asynchronous reset in the middle of HOLD, well away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", cyc, pk(0,0,0,0,0,0,8'h00,8'h00));
        @(negedge CLK);
        rst = 1'b0;
        cyc = -1;
        step();
        checkOutput("post_reset_cnt0", cyc, pk(0,1,0,0,0,0,8'h00,8'h00));
        stepTo(10);
        checkOutput("post_reset_start", cyc, pk(1,1,0,0,0,0,8'h00,8'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_adc_scheduler.md
# led_adc_scheduler

Sequences the pulse-oximeter finger-clip front end. It alternates the red and infrared LEDs at 100 Hz (5 ms per LED), waits for the optical path to settle, and runs one handshaked conversion on the shared 8-bit ADC per LED phase. It steers each sample to the matching channel register and strobes a one-cycle valid that advances the RED or IR FIR filter. It sits between the ADC interface and the two FIR filter instances.

## Interface
- HALF_PERIOD_CYC, 50000: cycles per LED phase (5 ms at 10 MHz).
- SETTLE_CYC, 10000: cycles from phase start to ADC_Start. Must be ≥ 1.
- ADC_TIMEOUT_CYC, 1000: maximum cycles to wait for ADC_Done. Constraint: SETTLE_CYC + ADC_TIMEOUT_CYC + 2 < HALF_PERIOD_CYC.
- CLK  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- Enable  in  1  level; runs the schedule while high.
- Err_Clr  in  1  one-cycle pulse; clears ADC_Timeout_Err.
- ADC_Data  in  8  conversion result; valid when ADC_Done = 1.
- ADC_Done  in  1  one-cycle completion pulse from the ADC.
- ADC_Start  out  1  one-cycle convert request.
- LED_RED_On  out  1  red LED drive.
- LED_IR_On  out  1  infrared LED drive.
- RED_ADC_Value  out  8  last good red sample.
- IR_ADC_Value  out  8  last good IR sample.
- RED_Sample_Valid  out  1  one-cycle strobe on each RED_ADC_Value update.
- IR_Sample_Valid  out  1  one-cycle strobe on each IR_ADC_Value update.
- ADC_Timeout_Err  out  1  sticky timeout flag.

## Operation
- States: IDLE, SETTLE, CONVERT, WAIT_DONE, HOLD. The phase bit is 0 for RED and 1 for IR.
- Phase counter: counts 0 to HALF_PERIOD_CYC−1 while not in IDLE. At the terminal count it wraps to 0, toggles the phase and forces SETTLE, whatever the current state.
- LED drive:
  - LED_RED_On = (state ≠ IDLE) & phase = 0.
  - LED_IR_On = (state ≠ IDLE) & phase = 1.
  - The two LEDs are never on together.
- IDLE → SETTLE when Enable = 1. Phase = RED, counter = 0.
- SETTLE → CONVERT when counter = SETTLE_CYC−1.
- CONVERT: ADC_Start = 1 for exactly this one cycle, then → WAIT_DONE. A wait counter is cleared here.
- WAIT_DONE, ADC_Done = 1:
  - Latch ADC_Data into the register for the current phase.
  - Pulse that phase's valid.
  - → HOLD.
- WAIT_DONE timeout (wait counter = ADC_TIMEOUT_CYC−1, no Done):
  - Set ADC_Timeout_Err.
  - Keep the previous sample and issue no valid.
  - → HOLD.
- Done and timeout on the same cycle: Done wins, and no error is raised.
- HOLD: wait for the phase wrap.
- ADC_Done outside WAIT_DONE is ignored.
- Enable low in any state → IDLE on the next edge:
  - Counters are cleared and the phase is set to RED.
  - Any in-flight conversion is discarded; a later Done is ignored.
  - The sample registers keep their values.
- Err_Clr clears the error. If set and clear occur on the same cycle, set wins.
- The sample registers are unsigned 8-bit values and pass through unmodified.

## Timing
- Reset: state IDLE, phase RED, every output 0 (both values 8'd0, error 0).
- Phase counter 0 is the first cycle after IDLE→SETTLE or after a wrap.
- ADC_Start is high on counter = SETTLE_CYC.
- Done sampled at edge N → value and valid visible from cycle N+1; valid is low again at N+2.
- Sample rate is one sample per channel per 2·HALF_PERIOD_CYC cycles (100 Hz per channel).
- LED switching is registered, with no glitch at the wrap.

## Structure
- Shared package holds:
  - the state enum;
  - PHASE_RED / PHASE_IR constants;
  - the default cycle-count parameters, which the FIR filter clock planning also uses.
- One sub-module, phase_timer:
  - a counter with clear and enable;
  - outputs a terminal-count pulse and the current count;
  - instantiated for the phase counter and reused for the wait counter.

## Test plan
Bench parameters: HALF=100, SETTLE=10, TIMEOUT=20.
- Reset released, Enable=1, ADC answers Done 3 cycles after Start with 0x5A → ADC_Start at cycle 10; RED_ADC_Value=0x5A with a one-cycle RED_Sample_Valid; LED_RED_On high for cycles 0–99.
- Continue with the ADC answering 0xA5 → the IR phase starts at cycle 100; IR_ADC_Value=0xA5 with IR_Sample_Valid; LEDs never high together.
- No Done in the IR phase → ADC_Timeout_Err=1 at wait cycle 20; IR_ADC_Value stays 0xA5; no valid strobe. Err_Clr coincident with a new timeout → flag stays 1.
- Done arriving on the exact timeout cycle → sample latched, no error.
- Enable dropped during WAIT_DONE, then Done arrives → IDLE, LEDs off, Done ignored. Enable re-raised → the red phase restarts at counter 0.
- rst asserted mid-HOLD → all outputs 0 asynchronously; normal schedule resumes after release.
